scoreboard_warp_param: RTL and testbench
========================================

Name: scoreboard_warp_param

Overview:
Parametrised per-warp scoreboard, next generation of the fixed 4-entry warp scoreboard. Tracks up to DEPTH in-flight instructions per warp and flags RAW/WAW/WAR hazards for the instruction IBuffer presents at issue. Accepts NUM_CLR independent completion ports (ALU, MEM, replay, ...). New features:
- Early operand-read release, which retires WAR sources before writeback.
- Warp flush.
- Occupancy count.
- Sticky protocol-error flag.

Parameters:
DEPTH, 4, number of scoreboard entries (power of 2, >=2)
REG_W, 5, register ID width
NUM_CLR, 2, number of completion/clear ports
ID_W, $clog2(DEPTH), entry ID width (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
iss_src1  in  REG_W  source 1 register of candidate instruction
iss_src1_vld  in  1  source 1 used
iss_src2  in  REG_W  source 2 register
iss_src2_vld  in  1  source 2 used
iss_dst  in  REG_W  destination register
iss_dst_vld  in  1  destination written
iss_grt  in  1  issue granted: allocate entry alloc_id with the iss_* fields
rd_done_vld  in  1  operands of entry rd_done_id have been read
rd_done_id  in  ID_W  entry whose source fields are released
clr_vld  in  NUM_CLR  per-port completion strobe
clr_id  in  NUM_CLR*ID_W  per-port entry ID, port k at [k*ID_W +: ID_W]
flush  in  1  discard all entries (warp kill/exit)
full  out  1  no free entry in cleared view
empty  out  1  all entries free in cleared view
dependent  out  1  candidate hazards with a live entry
alloc_id  out  ID_W  entry to be allocated on iss_grt; returned later on a clr port
occupancy  out  ID_W+1  live entries in cleared view
err  out  1  sticky protocol error

Behaviour:
- Per-entry state: valid, src1_vld, src2_vld, dst_vld, src1, src2, dst. Only the valid/vld bits are reset; register fields are don't-care while invalid.
- Reset (rst=1 at posedge): all valid and vld bits 0, err 0. Outputs after reset: full=0, empty=1, dependent=0, alloc_id=0, occupancy=0.
- Cleared view (combinational), computed every cycle:
  - valid_c = valid minus every entry named by an asserted clr port.
  - srcN_vld_c = srcN_vld, cleared for rd_done_id when rd_done_vld.
  - full, empty, occupancy, alloc_id and dependent are all derived from the cleared view, giving zero-cycle clear-to-issue.
- alloc_id = lowest index with valid_c=0. When full it is 0 and meaningless.
- Hazard per live entry i, gated by valid_c[i]:
  - RAW: candidate srcN_vld && dst_vld[i] && srcN==dst[i], for N=1,2.
  - WAW: iss_dst_vld && dst_vld[i] && iss_dst==dst[i].
  - WAR: iss_dst_vld && srcN_vld_c[i] && iss_dst==srcN[i].
  - dependent = OR over entries of RAW|WAW|WAR.
- Next state:
  - valid <= valid_c.
  - If iss_grt && !full && !flush: entry alloc_id written with valid=1 and all iss_* fields, including the vld bits.
- Same-cycle events:
  - Clear and grant on the same entry: the clear frees it and the grant may reallocate it; the new contents win.
  - rd_done on the entry being allocated: the allocation wins, so the new src vld bits are stored.
  - Multiple clr ports naming the same entry: legal, single free.
  - flush: all valid <= 0 next cycle and any grant that cycle is dropped. Outputs that cycle still reflect the cleared view (flush is not combinational).
- err is set and held until rst when any of the following occurs:
  - iss_grt while full (grant dropped).
  - clr_vld[k] naming an entry whose valid is 0.
  - rd_done_vld naming an invalid entry.
  - Exception: these checks are suppressed in the flush cycle.
- dependent does not depend on iss_grt. The issue unit must not grant while dependent=1; this block does not check that.
- No latency beyond a single register stage. The cleared view is visible in the same cycle, and an allocation is visible from the next cycle.

Decomposition:
- Shared package gpu_scb_pkg: SCB_DEPTH, SCB_REG_W, SCB_NUM_CLR defaults; ID_W computation function; typedef scb_entry_t {valid, src1_vld, src2_vld, dst_vld, src1, src2, dst}.
- Sub-module scb_prio_enc: parametrised lowest-free-index encoder, also reused by IBuffer slot allocation.
- Hazard compare stays inline as a generate loop.

Test Plan:
- Reset then idle -> empty=1, full=0, occupancy=0, alloc_id=0, err=0.
- Four grants (DEPTH=4) with dst R1..R4 -> alloc_id 0,1,2,3, occupancy 4, full=1. Fifth grant -> dropped, err=1.
- Entry 0 holds dst=R5; candidate src1=R5 -> dependent=1. Same cycle clr_vld[1]=1, clr_id=0 -> dependent=0, alloc_id=0.
- Entry 1 holds src2=R9; candidate dst=R9 -> dependent=1 (WAR). rd_done_vld, rd_done_id=1 in that cycle -> dependent=0. Entry 1 remains valid, occupancy unchanged.
- Full scoreboard: flush with iss_grt=1 -> next cycle empty=1, occupancy=0, no entry allocated, err unchanged.
- clr on both ports naming entry 2 (valid) -> entry 2 freed once, err=0. Later clr of entry 2 while free -> err=1; persists until rst=1.

Source files
------------

// File: rtl/gpu_scb_pkg.sv
// Shared definitions for the warp scoreboard family.
//   SCB_DEPTH / SCB_REG_W / SCB_NUM_CLR : default parameter values
//   scb_id_w()                          : entry ID width for a given depth
//   scb_entry_t                         : one scoreboard entry at default widths
package gpu_scb_pkg;

  localparam int SCB_DEPTH   = 4;
  localparam int SCB_REG_W   = 5;
  localparam int SCB_NUM_CLR = 2;

  // Depth 1 would give a zero-width ID; keep at least one bit.
  function automatic int scb_id_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 src1_vld;
    logic                 src2_vld;
    logic                 dst_vld;
    logic [SCB_REG_W-1:0] src1;
    logic [SCB_REG_W-1:0] src2;
    logic [SCB_REG_W-1:0] dst;
  } scb_entry_t;

endpackage

// File: rtl/scb_prio_enc.sv
// Lowest-index encoder over a request vector.
//   req_i   : one bit per slot, 1 = slot is a candidate (e.g. free)
//   idx_o   : index of the lowest set bit, 0 when none is set
//   found_o : at least one bit of req_i is set
module scb_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scoreboard_warp_param.sv
// Per-warp scoreboard with DEPTH in-flight entries and NUM_CLR completion ports.
// Flags RAW/WAW/WAR hazards of the candidate instruction against live entries.
// All status outputs come from the "cleared view": current state with this
// cycle's completions and operand-read releases already applied, so a clear
// and a dependent issue can happen in the same cycle.
//   clk, rst          : clock, synchronous active-high reset
//   iss_*             : candidate instruction fields; iss_grt allocates alloc_id
//   rd_done_vld/_id   : operands of an entry have been read (drops its WAR sources)
//   clr_vld/clr_id    : per-port completion; port k id at [k*ID_W +: ID_W]
//   flush             : drop every entry next cycle, grant this cycle ignored
//   full, empty       : no free / all free entries in the cleared view
//   dependent         : candidate hazards with a live entry
//   alloc_id          : lowest free entry in the cleared view (0 when full)
//   occupancy         : live entries in the cleared view
//   err               : sticky protocol error, cleared only by rst
module scoreboard_warp_param
  import gpu_scb_pkg::*;
#(
  parameter int  DEPTH   = SCB_DEPTH,
  parameter int  REG_W   = SCB_REG_W,
  parameter int  NUM_CLR = SCB_NUM_CLR,
  localparam int ID_W    = scb_id_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_W-1:0]        iss_src1,
  input  logic                    iss_src1_vld,
  input  logic [REG_W-1:0]        iss_src2,
  input  logic                    iss_src2_vld,
  input  logic [REG_W-1:0]        iss_dst,
  input  logic                    iss_dst_vld,
  input  logic                    iss_grt,
  input  logic                    rd_done_vld,
  input  logic [ID_W-1:0]         rd_done_id,
  input  logic [NUM_CLR-1:0]      clr_vld,
  input  logic [NUM_CLR*ID_W-1:0] clr_id,
  input  logic                    flush,
  output logic                    full,
  output logic                    empty,
  output logic                    dependent,
  output logic [ID_W-1:0]         alloc_id,
  output logic [ID_W:0]           occupancy,
  output logic                    err
);

  // Control state (reset) and register fields (no reset, don't-care when invalid)
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] s1v_q, s1v_d;
  logic [DEPTH-1:0] s2v_q, s2v_d;
  logic [DEPTH-1:0] dv_q, dv_d;
  logic             err_q, err_d;
  logic [REG_W-1:0] src1_q [DEPTH];
  logic [REG_W-1:0] src2_q [DEPTH];
  logic [REG_W-1:0] dst_q  [DEPTH];

  logic [DEPTH-1:0] clr_mask, rd_mask;
  logic [DEPTH-1:0] valid_c, s1v_c, s2v_c;
  logic [DEPTH-1:0] haz;
  logic             clr_err, rd_err;
  logic             any_free;
  logic             we;
  logic [ID_W:0]    occ_c;

  // Completion ports: several ports may name the same entry; it is freed once.
  always_comb begin
    clr_mask = '0;
    clr_err  = 1'b0;
    for (int k = 0; k < NUM_CLR; k++) begin
      if (clr_vld[k]) begin
        clr_mask[clr_id[k*ID_W +: ID_W]] = 1'b1;
        if (!valid_q[clr_id[k*ID_W +: ID_W]]) clr_err = 1'b1;
      end
    end
  end

  always_comb begin
    rd_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_mask[i] = rd_done_vld && (rd_done_id == ID_W'(i));
    end
  end

  assign rd_err  = rd_done_vld && !valid_q[rd_done_id];
  assign valid_c = valid_q & ~clr_mask;
  assign s1v_c   = s1v_q & ~rd_mask;
  assign s2v_c   = s2v_q & ~rd_mask;

  scb_prio_enc #(
    .N     (DEPTH),
    .IDX_W (ID_W)
  ) u_free_enc (
    .req_i   (~valid_c),
    .idx_o   (alloc_id),
    .found_o (any_free)
  );

  always_comb begin
    occ_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_c = occ_c + {{ID_W{1'b0}}, valid_c[i]};
    end
  end

  assign full      = !any_free;
  assign empty     = (valid_c == '0);
  assign occupancy = occ_c;
  assign err       = err_q;

  // RAW/WAW compare against the stored dst; WAR only against sources not yet read.
  for (genvar i = 0; i < DEPTH; i++) begin : g_haz
    logic raw, waw, war;
    assign raw = dv_q[i] && ((iss_src1_vld && (iss_src1 == dst_q[i])) ||
                             (iss_src2_vld && (iss_src2 == dst_q[i])));
    assign waw = iss_dst_vld && dv_q[i] && (iss_dst == dst_q[i]);
    assign war = iss_dst_vld && ((s1v_c[i] && (iss_dst == src1_q[i])) ||
                                 (s2v_c[i] && (iss_dst == src2_q[i])));
    assign haz[i] = valid_c[i] && (raw || waw || war);
  end

  assign dependent = |haz;

  // A grant overrides any clear or operand release landing on the same entry.
  assign we = iss_grt && any_free && !flush;

  always_comb begin
    valid_d = valid_c;
    s1v_d   = s1v_c;
    s2v_d   = s2v_c;
    dv_d    = dv_q;
    if (flush) begin
      valid_d = '0;
    end else if (we) begin
      valid_d[alloc_id] = 1'b1;
      s1v_d[alloc_id]   = iss_src1_vld;
      s2v_d[alloc_id]   = iss_src2_vld;
      dv_d[alloc_id]    = iss_dst_vld;
    end
    err_d = err_q | (!flush && ((iss_grt && !any_free) || clr_err || rd_err));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      s1v_q   <= '0;
      s2v_q   <= '0;
      dv_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      s1v_q   <= s1v_d;
      s2v_q   <= s2v_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      src1_q[alloc_id] <= iss_src1;
      src2_q[alloc_id] <= iss_src2;
      dst_q[alloc_id]  <= iss_dst;
    end
  end

endmodule

// File: tb/tb_scoreboard_warp_param.sv
module tb_scoreboard_warp_param;
  localparam int DEPTH = 4;
  localparam int REG_W = 5;
  localparam int NCLR  = 2;
  localparam int ID_W  = 2;

  logic clk = 1'b0;
  logic rst;
  logic [REG_W-1:0] iss_src1, iss_src2, iss_dst;
  logic iss_src1_vld, iss_src2_vld, iss_dst_vld, iss_grt;
  logic rd_done_vld;
  logic [ID_W-1:0] rd_done_id;
  logic [NCLR-1:0] clr_vld;
  logic [NCLR*ID_W-1:0] clr_id;
  logic flush;
  logic full, empty, dependent, err;
  logic [ID_W-1:0] alloc_id;
  logic [ID_W:0] occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scoreboard_warp_param #(.DEPTH(DEPTH), .REG_W(REG_W), .NUM_CLR(NCLR)) dut (
    .clk(clk), .rst(rst),
    .iss_src1(iss_src1), .iss_src1_vld(iss_src1_vld),
    .iss_src2(iss_src2), .iss_src2_vld(iss_src2_vld),
    .iss_dst(iss_dst), .iss_dst_vld(iss_dst_vld), .iss_grt(iss_grt),
    .rd_done_vld(rd_done_vld), .rd_done_id(rd_done_id),
    .clr_vld(clr_vld), .clr_id(clr_id), .flush(flush),
    .full(full), .empty(empty), .dependent(dependent),
    .alloc_id(alloc_id), .occupancy(occupancy), .err(err)
  );

  // Reference model: list of in-flight instructions per slot
  bit m_live[DEPTH];
  bit m_s1v[DEPTH], m_s2v[DEPTH], m_dv[DEPTH];
  int m_s1[DEPTH], m_s2[DEPTH], m_d[DEPTH];
  bit m_err;

  bit e_full, e_empty, e_dep;
  int e_alloc, e_occ;

  function automatic bit cleared(int i);
    for (int k = 0; k < NCLR; k++)
      if (clr_vld[k] && int'(clr_id[k*ID_W +: ID_W]) == i) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit still_live(int i);
    return m_live[i] && !cleared(i);
  endfunction

  function automatic void eval_exp();
    e_occ = 0; e_alloc = -1; e_dep = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (still_live(i)) begin
        bit rdrel;
        e_occ++;
        rdrel = rd_done_vld && int'(rd_done_id) == i;
        if (m_dv[i] && iss_src1_vld && int'(iss_src1) == m_d[i]) e_dep = 1'b1;
        if (m_dv[i] && iss_src2_vld && int'(iss_src2) == m_d[i]) e_dep = 1'b1;
        if (m_dv[i] && iss_dst_vld && int'(iss_dst) == m_d[i]) e_dep = 1'b1;
        if (!rdrel && m_s1v[i] && iss_dst_vld && int'(iss_dst) == m_s1[i]) e_dep = 1'b1;
        if (!rdrel && m_s2v[i] && iss_dst_vld && int'(iss_dst) == m_s2[i]) e_dep = 1'b1;
      end else if (e_alloc < 0) begin
        e_alloc = i;
      end
    end
    if (e_alloc < 0) e_alloc = 0;
    e_full  = (e_occ == DEPTH);
    e_empty = (e_occ == 0);
  endfunction

  function automatic void model_update();
    bit bad_op;
    eval_exp();
    bad_op = iss_grt && e_full;
    for (int k = 0; k < NCLR; k++)
      if (clr_vld[k] && !m_live[clr_id[k*ID_W +: ID_W]]) bad_op = 1'b1;
    if (rd_done_vld && !m_live[rd_done_id]) bad_op = 1'b1;
    if (!flush && bad_op) m_err = 1'b1;
    if (rd_done_vld) begin
      m_s1v[rd_done_id] = 1'b0;
      m_s2v[rd_done_id] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) m_live[i] = still_live(i) && !flush;
    if (iss_grt && !e_full && !flush) begin
      m_live[e_alloc] = 1'b1;
      m_s1v[e_alloc] = iss_src1_vld; m_s1[e_alloc] = int'(iss_src1);
      m_s2v[e_alloc] = iss_src2_vld; m_s2[e_alloc] = int'(iss_src2);
      m_dv[e_alloc]  = iss_dst_vld;  m_d[e_alloc]  = int'(iss_dst);
    end
  endfunction

  task automatic idle();
    iss_src1 = '0; iss_src2 = '0; iss_dst = '0;
    iss_src1_vld = 0; iss_src2_vld = 0; iss_dst_vld = 0; iss_grt = 0;
    rd_done_vld = 0; rd_done_id = '0; clr_vld = '0; clr_id = '0; flush = 0;
  endtask

  // Inputs change only at negedge; the model advances with the posedge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_live[i] = 0; m_s1v[i] = 0; m_s2v[i] = 0; m_dv[i] = 0;
      end
      m_err = 0;
    end else begin
      model_update();
    end
    @(negedge clk);
    #1;
    eval_exp();
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  task automatic grant(input int s1, input bit s1v, input int s2, input bit s2v,
                       input int d, input bit dv);
    iss_src1 = REG_W'(s1); iss_src1_vld = s1v;
    iss_src2 = REG_W'(s2); iss_src2_vld = s2v;
    iss_dst  = REG_W'(d);  iss_dst_vld  = dv;
    iss_grt  = 1;
  endtask

  task automatic test_reset();
    do_reset(); step();
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++;
      $display("FAIL reset_empty_full: got empty=%b full=%b want 1 0", empty, full); end
    total++; if (occupancy !== 0 || alloc_id !== 0) begin bad++;
      $display("FAIL reset_occ_alloc: got occ=%0d alloc=%0d want 0 0", occupancy, alloc_id); end
    total++; if (err !== 1'b0 || dependent !== 1'b0) begin bad++;
      $display("FAIL reset_err_dep: got err=%b dep=%b want 0 0", err, dependent); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int n = 0; n < DEPTH; n++) begin
      grant(0, 0, 0, 0, n + 1, 1);
      #1;
      total++; if (alloc_id !== ID_W'(n)) begin bad++;
        $display("FAIL fill_alloc: got %0d want %0d", alloc_id, n); end
      step();
    end
    idle(); #1;
    total++; if (occupancy !== 3'(DEPTH) || full !== 1'b1) begin bad++;
      $display("FAIL fill_full: got occ=%0d full=%b want %0d 1", occupancy, full, DEPTH); end
    grant(0, 0, 0, 0, 7, 1); step(); idle(); #1;
    total++; if (err !== 1'b1 || occupancy !== 3'(DEPTH)) begin bad++;
      $display("FAIL fill_overgrant: got err=%b occ=%0d want 1 %0d", err, occupancy, DEPTH); end
  endtask

  task automatic test_raw_clear();
    do_reset();
    grant(0, 0, 0, 0, 5, 1); step(); idle();
    iss_src1 = 5; iss_src1_vld = 1; #1;
    total++; if (dependent !== 1'b1) begin bad++;
      $display("FAIL raw_dep: got %b want 1", dependent); end
    clr_vld = 2'b10; clr_id = 4'b00_00; #1;
    total++; if (dependent !== 1'b0 || alloc_id !== 0) begin bad++;
      $display("FAIL raw_clear: got dep=%b alloc=%0d want 0 0", dependent, alloc_id); end
    step(); idle();
  endtask

  task automatic test_war_rddone();
    do_reset();
    grant(0, 0, 0, 0, 1, 1); step();
    grant(0, 0, 9, 1, 2, 1); step(); idle();
    iss_dst = 9; iss_dst_vld = 1; #1;
    total++; if (dependent !== 1'b1) begin bad++;
      $display("FAIL war_dep: got %b want 1", dependent); end
    rd_done_vld = 1; rd_done_id = 1; #1;
    total++; if (dependent !== 1'b0) begin bad++;
      $display("FAIL war_rddone: got %b want 0", dependent); end
    step(); rd_done_vld = 0; #1;
    total++; if (dependent !== 1'b0 || occupancy !== 2 || err !== 1'b0) begin bad++;
      $display("FAIL war_after: got dep=%b occ=%0d err=%b want 0 2 0", dependent, occupancy, err); end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    for (int n = 0; n < DEPTH; n++) begin grant(0, 0, 0, 0, n, 1); step(); end
    idle(); flush = 1; iss_grt = 1; #1;
    total++; if (full !== 1'b1 || occupancy !== 3'(DEPTH)) begin bad++;
      $display("FAIL flush_same_cycle: got full=%b occ=%0d want 1 %0d", full, occupancy, DEPTH); end
    step(); idle(); #1;
    total++; if (empty !== 1'b1 || occupancy !== 0 || err !== 1'b0) begin bad++;
      $display("FAIL flush_next: got empty=%b occ=%0d err=%b want 1 0 0", empty, occupancy, err); end
  endtask

  task automatic test_dup_clr_err();
    do_reset();
    for (int n = 0; n < 3; n++) begin grant(0, 0, 0, 0, n, 1); step(); end
    idle(); clr_vld = 2'b11; clr_id = 4'b10_10; step(); idle(); #1;
    total++; if (occupancy !== 2 || err !== 1'b0 || alloc_id !== 2) begin bad++;
      $display("FAIL dup_clr: got occ=%0d err=%b alloc=%0d want 2 0 2", occupancy, err, alloc_id); end
    clr_vld = 2'b01; clr_id = 4'b00_10; step(); idle();
    step(); step(); #1;
    total++; if (err !== 1'b1) begin bad++;
      $display("FAIL clr_free_err: got %b want 1", err); end
    do_reset(); #1;
    total++; if (err !== 1'b0) begin bad++;
      $display("FAIL err_rst: got %b want 0", err); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 59) do_reset();
      iss_src1 = REG_W'($urandom_range(0, 5)); iss_src1_vld = 1'($urandom);
      iss_src2 = REG_W'($urandom_range(0, 5)); iss_src2_vld = 1'($urandom);
      iss_dst  = REG_W'($urandom_range(0, 5)); iss_dst_vld  = 1'($urandom);
      iss_grt  = ($urandom_range(0, 2) != 0);
      rd_done_vld = ($urandom_range(0, 3) == 0); rd_done_id = ID_W'($urandom);
      clr_vld = NCLR'($urandom_range(0, 3) == 0 ? $urandom : 0);
      clr_id  = (NCLR*ID_W)'($urandom);
      flush = ($urandom_range(0, 24) == 0);
      #1; eval_exp();
      total++;
      if (full !== e_full || empty !== e_empty || dependent !== e_dep ||
          alloc_id !== ID_W'(e_alloc) || occupancy !== 3'(e_occ) || err !== m_err) begin
        bad++;
        $display("FAIL random_c%0d: got full=%b empty=%b dep=%b alloc=%0d occ=%0d err=%b want %b %b %b %0d %0d %b",
                 c, full, empty, dependent, alloc_id, occupancy, err,
                 e_full, e_empty, e_dep, e_alloc, e_occ, m_err);
      end
      step();
    end
    idle();
  endtask

  initial begin
    idle(); rst = 1;
    @(negedge clk);
    test_reset();
    test_fill();
    test_raw_clear();
    test_war_rddone();
    test_flush();
    test_dup_clr_err();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
